// File: rtl/fc_pkg.sv
// Shared definitions for the fc3 output-layer sequencer.
//   Layer geometry (N_IN, IN_W, N_CLS), class-code width and tie code,
//   FSM state encodings, the buffered result payload and the one-hot encoder.
package fc_pkg;

  localparam int unsigned N_IN  = 32;
  localparam int unsigned IN_W  = 4;
  localparam int unsigned N_CLS = 10;
  localparam int unsigned CLS_W = 4;

  localparam logic [CLS_W-1:0] TIE_CODE = 4'hF;

  // FSM states (fixed encodings, shared with legacy tooling)
  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t SETTLE = 2'd1;
  localparam state_t SAMPLE = 2'd2;

  // One buffered classification result
  typedef struct packed {
    logic [CLS_W-1:0] cls;
    logic             tie;
  } result_t;

  // Encode the layer's one-hot argmax; zero or multiple set bits mean a tie
  function automatic result_t onehot_to_class(input logic [N_CLS-1:0] oh);
    result_t     r;
    int unsigned n;
    r.cls = '0;
    r.tie = 1'b0;
    n     = 0;
    for (int i = 0; i < int'(N_CLS); i++) begin
      if (oh[i]) begin
        n++;
        r.cls = CLS_W'(i);
      end
    end
    if (n != 1) begin
      r.cls = TIE_CODE;
      r.tie = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fc_result_fifo.sv
// Small synchronous result FIFO with occupancy count.
//   clk, rst        : clock, asynchronous active-high reset
//   push, push_data : write an entry (dropped only if full with no pop)
//   pop             : remove head entry; ignored when empty
//   head            : head entry, all-zero when empty
//   count           : current occupancy 0..DEPTH
module fc_result_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 5,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [PTR_W:0] count
);

  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = (count == '0) ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; head is masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fc3_sequencer.sv
// Sequencer for the 10-class output FC layer.
//   Accepts an activation vector (in_valid/in_ready), holds it on fc_in for
//   the layer's two-cycle settle, samples the one-hot fc_out, encodes it to a
//   class index / tie flag and queues it toward the consumer.
//   in_*      : activation handshake and vector
//   fc_in     : held vector to the layer; fc_out: one-hot argmax from it
//   res_*     : head of result FIFO (class, tie) with valid/ready pop
//   busy      : a vector is in flight
//   done_cnt  : results pushed since reset (wraps)
module fc3_sequencer
  import fc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*IN_W-1:0]   in_data,
  output logic [N_IN*IN_W-1:0]   fc_in,
  input  logic [N_CLS-1:0]       fc_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [CLS_W-1:0]       res_class,
  output logic                   res_tie,
  output logic                   busy,
  output logic [CNT_W-1:0]       done_cnt
);

  localparam int unsigned F_CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t               state;
  state_t               state_nxt;
  logic                 accept_c;
  logic                 push_c;
  logic [F_CNT_W-1:0]   fifo_count;
  result_t              push_res_c;
  result_t              head_res;

  // Slot is reserved at acceptance, so the later push can never overflow
  assign in_ready = !rst && (state == IDLE) &&
                    (fifo_count < F_CNT_W'(FIFO_DEPTH));
  assign accept_c   = in_valid && in_ready;
  assign push_c     = (state == SAMPLE);
  assign push_res_c = onehot_to_class(fc_out);
  assign busy       = (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c) state_nxt = SETTLE;
      SETTLE:  state_nxt = SAMPLE;
      SAMPLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Holding register: keeps the vector until the next acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           fc_in <= '0;
    else if (accept_c) fc_in <= in_data;
  end

  // Completed-classification counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         done_cnt <= '0;
    else if (push_c) done_cnt <= done_cnt + CNT_W'(1);
  end

  fc_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(result_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .push_data (push_res_c),
    .pop       (res_ready),
    .head      (head_res),
    .count     (fifo_count)
  );

  assign res_valid = (fifo_count != '0);
  assign res_class = head_res.cls;
  assign res_tie   = head_res.tie;

endmodule

// File: tb/tb_fc3_sequencer.sv
// Directed self-checking bench for fc3_sequencer.
module tb_fc3_sequencer;
  import fc_pkg::*;

  localparam int unsigned VEC_W    = N_IN * IN_W;
  localparam int unsigned TB_CNT_W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [VEC_W-1:0]    in_data;
  logic [VEC_W-1:0]    fc_in;
  logic [N_CLS-1:0]    fc_out;
  logic                res_valid;
  logic                res_ready;
  logic [CLS_W-1:0]    res_class;
  logic                res_tie;
  logic                busy;
  logic [TB_CNT_W-1:0] done_cnt;

  int checks = 0;
  int errors = 0;
  int exp_done = 0;

  fc3_sequencer #(.FIFO_DEPTH(2), .CNT_W(TB_CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .fc_in     (fc_in),
    .fc_out    (fc_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_class (res_class),
    .res_tie   (res_tie),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] rnd_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer one vector, check hold/busy through SETTLE and SAMPLE,
  // return at the negedge right after the push edge.
  task automatic offer(input logic [VEC_W-1:0] d, input logic [N_CLS-1:0] oh);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    fc_out   = oh;
    while (in_ready !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("accept_wait", {127'b0, in_ready}, 1);
    tick();
    chk("settle_busy", {127'b0, busy}, 1);
    chk("settle_ready", {127'b0, in_ready}, 0);
    chk("settle_hold", fc_in, d);
    in_data = rnd_vec();
    tick();
    chk("sample_busy", {127'b0, busy}, 1);
    chk("sample_ready", {127'b0, in_ready}, 0);
    chk("sample_hold", fc_in, d);
    in_data  = rnd_vec();
    in_valid = 1'b0;
    tick();
    exp_done++;
    chk("done_cnt", VEC_W'(done_cnt), VEC_W'(TB_CNT_W'(exp_done)));
    chk("idle_busy", {127'b0, busy}, 0);
  endtask

  initial begin
    logic [VEC_W-1:0] v;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    fc_out    = '0;
    res_ready = 1'b0;

    // Reset state
    tick();
    chk("rst_in_ready", {127'b0, in_ready}, 0);
    chk("rst_busy", {127'b0, busy}, 0);
    chk("rst_res_valid", {127'b0, res_valid}, 0);
    chk("rst_res_class", VEC_W'(res_class), 0);
    chk("rst_res_tie", {127'b0, res_tie}, 0);
    chk("rst_done_cnt", VEC_W'(done_cnt), 0);
    chk("rst_fc_in", fc_in, 0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", {127'b0, in_ready}, 1);

    // Single vector, class 3, consumer ready
    res_ready = 1'b1;
    v = rnd_vec();
    offer(v, 10'b0000001000);
    chk("single_valid", {127'b0, res_valid}, 1);
    chk("single_class", VEC_W'(res_class), 3);
    chk("single_tie", {127'b0, res_tie}, 0);
    chk("hold_after_done", fc_in, v);
    tick();
    chk("single_popped", {127'b0, res_valid}, 0);
    chk("popped_class", VEC_W'(res_class), 0);

    // Ties: no bits, two bits
    offer(rnd_vec(), 10'b0000000000);
    chk("tie0_class", VEC_W'(res_class), 15);
    chk("tie0_tie", {127'b0, res_tie}, 1);
    offer(rnd_vec(), 10'b0000000011);
    chk("tie2_class", VEC_W'(res_class), 15);
    chk("tie2_tie", {127'b0, res_tie}, 1);
    tick();
    chk("tie_popped", {127'b0, res_valid}, 0);

    // Backpressure: classes 1,2 fill the FIFO, class 7 must wait
    res_ready = 1'b0;
    offer(rnd_vec(), 10'b0000000010);
    offer(rnd_vec(), 10'b0000000100);
    chk("bp_head1", VEC_W'(res_class), 1);
    in_valid = 1'b1;
    in_data  = rnd_vec();
    fc_out   = 10'b0010000000;
    for (int i = 0; i < 3; i++) begin
      chk("bp_not_ready", {127'b0, in_ready}, 0);
      chk("bp_head_still1", VEC_W'(res_class), 1);
      tick();
    end
    res_ready = 1'b1;
    tick();
    chk("bp_head2", VEC_W'(res_class), 2);
    chk("bp_ready_again", {127'b0, in_ready}, 1);
    offer(rnd_vec(), 10'b0010000000);
    chk("bp_third_class", VEC_W'(res_class), 7);
    chk("bp_third_tie", {127'b0, res_tie}, 0);
    tick();
    chk("bp_drained", {127'b0, res_valid}, 0);

    // Reset pulse during SETTLE with one result buffered
    res_ready = 1'b0;
    offer(rnd_vec(), 10'b0000100000);
    chk("pre_rst_class", VEC_W'(res_class), 5);
    in_valid = 1'b1;
    in_data  = rnd_vec();
    fc_out   = 10'b0000000001;
    chk("pre_rst_ready", {127'b0, in_ready}, 1);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_busy", {127'b0, busy}, 1);
    rst = 1'b1;
    #1;
    chk("async_busy", {127'b0, busy}, 0);
    chk("async_res_valid", {127'b0, res_valid}, 0);
    chk("async_done_cnt", VEC_W'(done_cnt), 0);
    chk("async_in_ready", {127'b0, in_ready}, 0);
    exp_done = 0;
    tick();
    tick();
    chk("rst_no_push", {127'b0, res_valid}, 0);
    rst = 1'b0;
    res_ready = 1'b1;
    tick();
    offer(rnd_vec(), 10'b1000000000);
    chk("post_rst_class", VEC_W'(res_class), 9);
    chk("post_rst_valid", {127'b0, res_valid}, 1);
    tick();

    // Back-to-back stream: in_ready every third cycle, counter wraps
    in_valid = 1'b1;
    fc_out   = 10'b0000000001;
    for (int c = 0; c < 780; c++) begin
      in_data = rnd_vec();
      chk("b2b_ready", {127'b0, in_ready}, (c % 3 == 0) ? 1 : 0);
      tick();
    end
    in_valid = 1'b0;
    exp_done += 260;
    chk("b2b_done_wrap", VEC_W'(done_cnt), VEC_W'(TB_CNT_W'(exp_done)));
    chk("b2b_last_class", VEC_W'(res_class), 0);
    chk("b2b_last_valid", {127'b0, res_valid}, 1);
    tick();
    chk("b2b_empty", {127'b0, res_valid}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc3_sequencer.md
Name: fc3_sequencer

Overview:
Controller that sequences the 10-class output fully-connected layer (32 x 4-bit activations in, one-hot argmax out).
- The layer registers its shared partial sums for one cycle, so its inputs must be held stable for two consecutive cycles before its one-hot result is valid.
- This block accepts activation vectors over a valid/ready handshake and drives the layer's inputs from a holding register.
- It samples the one-hot at the correct cycle, encodes it to a class index with tie detection, and buffers results in a small FIFO toward the consumer.

Parameters:
N_IN, 32, number of input activations
IN_W, 4, bits per activation
N_CLS, 10, number of classes (one-hot width)
FIFO_DEPTH, 2, result buffer entries (power of two, >=2)
CNT_W, 16, width of completed-classification counter

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  activation vector offered
in_ready  output  1  vector accepted this cycle when in_valid&&in_ready
in_data  input  N_IN*IN_W  activation vector, element i at bits [i*IN_W +: IN_W]
fc_in  output  N_IN*IN_W  held vector driven to the layer, same packing
fc_out  input  N_CLS  one-hot argmax from the layer (all-zero on tie)
res_valid  output  1  result FIFO non-empty
res_ready  input  1  consumer pops head when res_valid&&res_ready
res_class  output  4  head class index 0..N_CLS-1, 4'hF on tie
res_tie  output  1  head result was a tie
busy  output  1  state != IDLE
done_cnt  output  CNT_W  classifications pushed into FIFO since reset

Behaviour:
- Reset (async, rst=1): state=IDLE, fc_in=0, FIFO empty, res_valid=0, res_class=0, res_tie=0, busy=0, done_cnt=0, in_ready=0 while rst is high.
- FSM states IDLE, SETTLE, SAMPLE.
- IDLE: in_ready = (fifo_count < FIFO_DEPTH). On handshake, fc_in <= in_data, go to SETTLE. Otherwise stay.
- SETTLE: one cycle; the layer's shared-term registers capture from the held fc_in. in_ready=0. Unconditional -> SAMPLE.
- SAMPLE: fc_out is valid. At the end of this cycle, push {class,tie} into the FIFO, done_cnt++, -> IDLE. in_ready=0.
- A FIFO slot is reserved at acceptance (at most one vector in flight), so the push in SAMPLE never overflows. Pops during SETTLE/SAMPLE only free space.
- Latency: handshake at edge k -> push at edge k+2 -> res_valid=1 in the cycle after edge k+2 (FIFO previously empty).
- Throughput: one vector per 3 cycles maximum; in_ready is never high in consecutive cycles.
- fc_in holds its value from acceptance until the next acceptance; it is not cleared in IDLE.
- Encoding:
  - exactly one bit set -> res_class = bit index, tie=0;
  - zero bits or more than one bit set -> res_class=4'hF, tie=1.
  - The value is registered into the FIFO, never passed combinationally.
- FIFO:
  - res_class/res_tie reflect the head entry; they are 0/0 when empty.
  - Simultaneous push and pop: count unchanged, order preserved.
  - A pop when empty is ignored.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- done_cnt wraps from 2^CNT_W-1 to 0 without a flag.
- Reset asserted in SETTLE/SAMPLE: the in-flight vector is discarded, with no push and no count increment. Buffered results are lost.
- in_data/in_valid are ignored outside IDLE; a vector offered while in_ready=0 must be held by the producer (standard valid/ready; valid must not drop before handshake).

Decomposition:
- Shared package fc_pkg:
  - N_IN, IN_W, N_CLS, CLS_W=4, TIE_CODE=4'hF;
  - state enum {IDLE, SETTLE, SAMPLE};
  - result struct {class, tie};
  - function onehot_to_class (returns {class, tie}).
- One sub-module: fc_result_fifo (parameterised sync FIFO, depth FIFO_DEPTH, async reset, count output).
- FSM, holding register and counter stay in fc3_sequencer.

Test Plan:
- Single vector, fc_out stub=10'b0000001000, res_ready=1: handshake at edge k -> res_valid at cycle k+3 with res_class=3, res_tie=0, then pops; done_cnt=1.
- Tie: stub fc_out=10'b0 -> res_class=4'hF, res_tie=1. Stub fc_out=10'b0000000011 -> res_class=4'hF, res_tie=1.
- Backpressure, res_ready=0, in_valid held high with classes 1,2,7: two results accepted, then in_ready stays 0. Raise res_ready -> pops 1,2 in order; the third vector is then accepted and yields 7.
- Hold check: change in_data every cycle after acceptance -> fc_in equals the accepted vector throughout SETTLE/SAMPLE.
- Reset pulse during SETTLE: busy=0, res_valid=0, done_cnt=0 immediately (async). The next vector completes normally with 3-cycle latency.
- Back-to-back 70000 vectors with res_ready=1 -> in_ready pulses every 3rd cycle, done_cnt wraps to 70000-65536=4464.
